// File: rtl/mux_arb.sv
// mux_arb: round-robin arbiter for two requesters sharing a 2:1 mux.
// It supports hold-limit preemption and optional turnaround (dead) cycles between grants.
module mux_arb #(
    parameter int HOLD_MAX = 8,
    parameter int TURN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic last_a,
    input  logic last_b,
    output logic sel,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy
);
    typedef enum logic [1:0] {S_IDLE, S_GNT_A, S_GNT_B, S_TURN} state_t;
    localparam logic [7:0] HM = 8'(HOLD_MAX);
    localparam logic [1:0] TL = 2'(TURN - 1);
    state_t     r_state;
    logic       r_ptr;
    logic       r_rdy;
    logic [7:0] r_hold;
    logic [1:0] r_tcnt;
    logic       w_ra, w_rb, w_la, w_lb, w_rel, w_arb, w_ga, w_gb;
    // Only a solid 1 counts as asserted, so x/z on the inputs can never produce a grant.
    always_comb begin
        w_ra  = (req_a === 1'b1);
        w_rb  = (req_b === 1'b1);
        w_la  = (last_a === 1'b1);
        w_lb  = (last_b === 1'b1);
        w_rel = (r_state == S_GNT_A) ? (!w_ra || w_la || (r_hold == HM && w_rb)) :
                (r_state == S_GNT_B) ? (!w_rb || w_lb || (r_hold == HM && w_ra)) : 1'b0;
        w_arb = (r_state == S_IDLE && r_rdy) || (r_state == S_TURN && r_tcnt == 2'd0) ||
                (w_rel && TURN == 0);
        w_ga  = w_arb && w_ra && (!w_rb || !r_ptr);
        w_gb  = w_arb && w_rb && (!w_ra || r_ptr);
    end
    // r_rdy holds off arbitration for the first edge after reset; r_ptr=1 means B has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b0;
            sel     <= 1'b0;
            r_ptr   <= 1'b0;
            r_rdy   <= 1'b0;
            r_hold  <= 8'd0;
            r_tcnt  <= 2'd0;
        end else begin
            r_rdy <= 1'b1;
            if (w_ga || w_gb) begin
                r_state <= w_ga ? S_GNT_A : S_GNT_B;
                gnt_a   <= w_ga;
                gnt_b   <= w_gb;
                sel     <= w_gb;
                busy    <= 1'b1;
                r_ptr   <= w_ga;
                r_hold  <= 8'd1;
            end else if (w_rel) begin
                r_state <= (TURN > 0) ? S_TURN : S_IDLE;
                gnt_a   <= 1'b0;
                gnt_b   <= 1'b0;
                busy    <= (TURN > 0);
                r_hold  <= 8'd0;
                r_tcnt  <= TL;
            end else if (r_state == S_TURN) begin
                if (r_tcnt == 2'd0) begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt - 2'd1;
                end
            end else if (r_hold != 8'd0 && r_hold != HM) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: vector table, directed corner sequences and randomized run against a reference model.
// Two instances are used: (HOLD_MAX=8, TURN=1) and (HOLD_MAX=3, TURN=0).
module tb_mux_arb;
    logic clk = 1'b0, rst = 1'b1;
    logic req_a = 1'b0, req_b = 1'b0, last_a = 1'b0, last_b = 1'b0;
    logic sel0, ga0, gb0, busy0, sel1, ga1, gb1, busy1;
    int   n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    mux_arb #(.HOLD_MAX(8), .TURN(1)) u0 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
        .sel(sel0), .gnt_a(ga0), .gnt_b(gb0), .busy(busy0)
    );
    mux_arb #(.HOLD_MAX(3), .TURN(0)) u1 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
        .sel(sel1), .gnt_a(ga1), .gnt_b(gb1), .busy(busy1)
    );

    // Model state: owner 0=none 1=A 2=B; pref = requester favoured on a tie.
    int m_own[2], m_dead[2], m_pref[2], m_hold[2];
    bit m_sel[2], m_arm[2];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = 0; m_dead[i] = 0; m_pref[i] = 1; m_hold[i] = 0; m_sel[i] = 0; m_arm[i] = 0;
        end
    endtask

    task automatic m_step(input int i, input int t, input int hm, input bit ra, input bit rb,
                          input bit la, input bit lb);
        int win;
        bit arb, mine, other, lst;
        arb = 0;
        if (!m_arm[i]) begin
            m_arm[i] = 1;
            return;
        end
        if (m_own[i] != 0) begin
            mine  = (m_own[i] == 1) ? ra : rb;
            other = (m_own[i] == 1) ? rb : ra;
            lst   = (m_own[i] == 1) ? la : lb;
            if (!mine || lst || (m_hold[i] == hm && other)) begin
                m_own[i] = 0;
                m_hold[i] = 0;
                if (t > 0) m_dead[i] = t; else arb = 1;
            end else if (m_hold[i] < hm) m_hold[i]++;
        end else if (m_dead[i] > 0) begin
            if (m_dead[i] == 1) arb = 1;
            m_dead[i]--;
        end else arb = 1;
        if (arb) begin
            win = (ra && rb) ? m_pref[i] : ra ? 1 : rb ? 2 : 0;
            if (win != 0) begin
                m_own[i] = win; m_hold[i] = 1; m_sel[i] = (win == 2); m_pref[i] = 3 - win;
            end
        end
    endtask

    function automatic logic [3:0] m_exp(input int i);
        return {m_own[i] == 1, m_own[i] == 2, m_sel[i], m_own[i] != 0 || m_dead[i] > 0};
    endfunction

    always @(posedge clk or posedge rst) begin
        bit ra, rb, la, lb;
        ra = (req_a === 1'b1); rb = (req_b === 1'b1); la = (last_a === 1'b1); lb = (last_b === 1'b1);
        if (rst) m_reset();
        else begin
            m_step(0, 1, 8, ra, rb, la, lb);
            m_step(1, 0, 3, ra, rb, la, lb);
        end
    end

    // act/exp are {gnt_a, gnt_b, sel, busy}
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got gnt_a,gnt_b,sel,busy=%b want %b", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic ra, input logic rb, input logic la, input logic lb);
        req_a = ra; req_b = rb; last_a = la; last_b = lb;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset0", {ga0, gb0, sel0, busy0}, 4'b0000);
        chk("reset1", {ga1, gb1, sel1, busy1}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic ra, rb, la, lb;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[17];

    initial begin
        logic [3:0] e;
        int r;
        tbl[0]  = 8'b0000_0000; tbl[1]  = 8'b1000_1001; tbl[2]  = 8'b1000_1001;
        tbl[3]  = 8'b1010_0001; tbl[4]  = 8'b0000_0000; tbl[5]  = 8'b0100_0111;
        tbl[6]  = 8'b1100_0111; tbl[7]  = 8'b1000_0011; tbl[8]  = 8'b1000_1001;
        tbl[9]  = 8'b1110_0001; tbl[10] = 8'b1100_0111; tbl[11] = 8'b0000_0011;
        tbl[12] = 8'b0x00_0010; tbl[13] = 8'b0x00_0010; tbl[14] = 8'b0100_0111;
        tbl[15] = 8'bx101_0011; tbl[16] = 8'b1000_1001;

        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].ra, tbl[i].rb, tbl[i].la, tbl[i].lb);
            @(negedge clk);
            chk($sformatf("tbl%0d", i), {ga0, gb0, sel0, busy0}, tbl[i].exp);
        end

        // X on req_b straight out of reset must not grant or move sel
        do_reset();
        set_in(0, 1'bx, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("xreq", {ga0, gb0, sel0, busy0}, 4'b0000);
        end
        set_in(0, 1, 0, 0);
        @(negedge clk);
        chk("xreq_then_b", {ga0, gb0, sel0, busy0}, 4'b0111);

        // Both requesting: 8 cycles A, 1 dead, 8 cycles B, 1 dead, A again
        do_reset();
        set_in(1, 1, 0, 0);
        @(negedge clk);
        chk("rr_arm", {ga0, gb0, sel0, busy0}, 4'b0000);
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            e = {c < 8 || c == 18, c >= 9 && c <= 16, c >= 9 && c <= 17, 1'b1};
            chk($sformatf("rr%0d", c), {ga0, gb0, sel0, busy0}, e);
        end

        // TURN=0: grant hands straight over with no dead cycle
        do_reset();
        set_in(1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t0_a", {ga1, gb1, sel1, busy1}, 4'b1001);
        set_in(1, 1, 1, 0);
        @(negedge clk);
        chk("t0_handover_b", {ga1, gb1, sel1, busy1}, 4'b0111);
        set_in(1, 0, 0, 0);
        @(negedge clk);
        chk("t0_back_a", {ga1, gb1, sel1, busy1}, 4'b1001);

        // Async reset in mid-grant clears outputs before the next edge
        do_reset();
        set_in(0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre", {ga0, gb0, sel0, busy0}, 4'b0111);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("ar_async", {ga0, gb0, sel0, busy0}, 4'b0000);
        set_in(1, 1, 0, 0);
        @(negedge clk);
        chk("ar_hold0", {ga0, gb0, sel0, busy0}, 4'b0000);
        @(negedge clk);
        chk("ar_hold1", {ga0, gb0, sel0, busy0}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_first_edge", {ga0, gb0, sel0, busy0}, 4'b0000);
        @(negedge clk);
        chk("ar_second_edge", {ga0, gb0, sel0, busy0}, 4'b1001);

        // Randomized run against the model, with x inputs and occasional reset pulses
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            req_a = (r == 0) ? 1'bx : (r < 6);
            r = $urandom_range(0, 9);
            req_b = (r == 0) ? 1'bx : (r < 6);
            r = $urandom_range(0, 11);
            last_a = (r == 0) ? 1'bx : (r < 3);
            r = $urandom_range(0, 11);
            last_b = (r == 0) ? 1'bx : (r < 3);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            chk("rand_u0", {ga0, gb0, sel0, busy0}, m_exp(0));
            chk("rand_u1", {ga1, gb1, sel1, busy1}, m_exp(1));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
